// File: rtl/chain_alu_pkg.sv
// rtl/chain_alu_pkg.sv - shared state and op-code types for chain_alu_stream
package chain_alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ANDOR  = 3'd0,
    OP_XORADD = 3'd1,
    OP_ABSDX  = 3'd2,
    OP_MINLO  = 3'd3,
    OP_MAXSH  = 3'd4,
    OP_SATAND = 3'd5,
    OP_AVG    = 3'd6,
    OP_ROTX   = 3'd7
  } op_t;

endpackage

// File: rtl/chain_alu_fn.sv
// rtl/chain_alu_fn.sv - combinational eight-function step unit for the accumulator
module chain_alu_fn
  import chain_alu_pkg::*;
#(
  parameter int N = 64
) (
  input  op_t          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] acc,
  output logic [N-1:0] result
);

  logic [N:0]     sum;
  logic           a_lt_b;
  logic [N-1:0]   abs_diff;
  logic [N-1:0]   max_ab;
  logic [N/2-1:0] min_lo;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign a_lt_b   = a < b;
  assign abs_diff = a_lt_b ? (b - a) : (a - b);
  assign max_ab   = a_lt_b ? b : a;
  assign min_lo   = a_lt_b ? a[N/2-1:0] : b[N/2-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ANDOR:  result = (a & b) | acc;
      OP_XORADD: result = (a ^ b) + acc;
      OP_ABSDX:  result = abs_diff ^ acc;
      OP_MINLO:  result = {acc[N-1:N/2], min_lo};
      OP_MAXSH:  result = max_ab + (acc << 1);
      // carry out of the add saturates the sum to all-ones
      OP_SATAND: result = (sum[N] ? {N{1'b1}} : sum[N-1:0]) & acc;
      OP_AVG:    result = ((a & b) + ((a ^ b) >> 1)) | acc;
      OP_ROTX:   result = {a[N-2:0], a[N-1]} ^ b ^ acc;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/chain_alu_stream.sv
// rtl/chain_alu_stream.sv - beat-serial operand load, op-stream accumulate, beat-serial drain
// CHAIN_ALU_ACC_KEEP_EN: keep acc across jobs instead of clearing it on start.
module chain_alu_stream
  import chain_alu_pkg::*;
#(
  parameter int N         = 64,
  parameter int W         = 4,
  parameter int MAX_STEPS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         op_valid,
  input  logic [2:0]   op_code,
  input  logic         op_last,
  output logic         op_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic [1:0]   state_o,
  output logic         step_err
);

  localparam int BEATS = N / W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = $clog2(MAX_STEPS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(MAX_STEPS);

  state_t        state, state_nx;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] step_cnt;
  logic [N-1:0]  a_reg, b_reg, acc, fn_result;
  logic          last_beat, step_limit;
  logic          in_fire, op_fire, out_fire;

  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign step_limit = ((step_cnt + SW'(1)) == STEP_MAX);
  assign in_fire    = in_valid & in_ready;
  assign op_fire    = op_valid & op_ready;
  assign out_fire   = out_valid & out_ready;

  chain_alu_fn #(.N(N)) u_fn (
    .op     (op_t'(op_code)),
    .a      (a_reg),
    .b      (b_reg),
    .acc    (acc),
    .result (fn_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  if (in_fire && last_beat) state_nx = EXEC;
      EXEC:  if (op_fire && (op_last || step_limit)) state_nx = DRAIN;
      DRAIN: if (out_fire && last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // handshake outputs depend on state only, never on the partner's valid
  always_comb begin
    in_ready  = (state == LOAD);
    op_ready  = (state == EXEC);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    state_o   = state;
    out_data  = out_valid ? acc[beat_cnt*W +: W] : '0;
    out_last  = out_valid && last_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      beat_cnt <= '0;
      step_cnt <= '0;
      step_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= '0;
            b_reg    <= '0;
            beat_cnt <= '0;
            step_cnt <= '0;
            step_err <= 1'b0;
`ifndef CHAIN_ALU_ACC_KEEP_EN
            acc      <= '0;
`endif
          end
        end
        LOAD: begin
          if (in_fire) begin
            a_reg[beat_cnt*W +: W] <= a_in;
            b_reg[beat_cnt*W +: W] <= b_in;
            beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
          end
        end
        EXEC: begin
          if (op_fire) begin
            acc      <= fn_result;
            step_cnt <= step_cnt + SW'(1);
            if (!op_last && step_limit) step_err <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_fire) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chain_alu_stream.sv
// tb/tb_chain_alu_stream.sv - randomized scoreboard bench for chain_alu_stream (N=16, W=4, MAX_STEPS=4)
module tb_chain_alu_stream;

  localparam int N = 16;
  localparam int W = 4;
  localparam int MS = 4;
  localparam int BEATS = N / W;

  logic         clk = 0;
  logic         rst = 1;
  logic         start = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         op_valid = 0;
  logic [2:0]   op_code = '0;
  logic         op_last = 0;
  logic         op_ready;
  logic         out_valid;
  logic         out_ready = 0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic [1:0]   state_o;
  logic         step_err;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic [N-1:0] model_acc = '0;
  int beats_seen = 0;
  int stall_cnt = 0;
  bit bp_en = 0;

  chain_alu_stream #(.N(N), .W(W), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .op_valid(op_valid), .op_code(op_code), .op_last(op_last), .op_ready(op_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .state_o(state_o), .step_err(step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each op written straight from its arithmetic definition on 16-bit values
  function automatic logic [N-1:0] ref_fn(input int code, input logic [N-1:0] a, b, acc);
    int unsigned ua, ub, uc, s;
    ua = a; ub = b; uc = acc; s = ua + ub;
    case (code)
      0: return (a & b) | acc;
      1: return N'((a ^ b) + uc);
      2: return N'((ua > ub) ? ua - ub : ub - ua) ^ acc;
      3: return {acc[N-1:N/2], 8'((ua < ub) ? ua : ub)};
      4: return N'(((ua > ub) ? ua : ub) + uc * 2);
      5: return ((s > 32'hFFFF) ? 16'hFFFF : N'(s)) & acc;
      6: return N'(s / 2) | acc;
      default: return N'((ua * 2) | (ua >> 15)) ^ b ^ acc;
    endcase
  endfunction

  task automatic push_result();
    for (int i = 0; i < BEATS; i++) exp_q.push_back({(i == BEATS - 1), model_acc[i*W +: W]});
  endtask

  // out_ready driver: forced stalls take priority over random backpressure
  initial forever begin
    @(posedge clk); #1;
    if (stall_cnt > 0) begin out_ready = 0; stall_cnt--; end
    else out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  logic         prev_stall = 0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  // Monitor: samples at the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {28'd0, out_data}, {28'd0, prev_data});
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (!out_valid) begin
        if (out_data !== '0) chk("idle_data_zero", {28'd0, out_data}, 32'd0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {27'd0, out_last, out_data}, 32'hFFFF);
        else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("beat_data", {28'd0, out_data}, {28'd0, e[W-1:0]});
          chk("beat_last", {31'd0, out_last}, {31'd0, e[W]});
        end
        beats_seen++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    int t;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (state_o == 2'd0) break;
    end
    if (t == 100) chk("wait_idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
    chk("step_err_cleared", {31'd0, step_err}, 32'd0);
`ifndef CHAIN_ALU_ACC_KEEP_EN
    model_acc = '0;
`endif
  endtask

  task automatic send_beat(input logic [W-1:0] a, b, input bit gaps);
    int t;
    if (gaps) cyc($urandom_range(0, 2));
    in_valid = 1; a_in = a; b_in = b;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 20) chk("in_ready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1; in_valid = 0; a_in = $urandom; b_in = $urandom;
  endtask

  task automatic send_op(input logic [2:0] c, input bit last, input bit gaps, output bit ok);
    int t;
    if (gaps) cyc($urandom_range(0, 2));
    op_valid = 1; op_code = c; op_last = last; ok = 0;
    for (t = 0; t < 10; t++) begin
      @(negedge clk);
      if (op_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1; op_valid = 0; op_last = 0;
  endtask

  task automatic load_operands(input logic [N-1:0] a, b, input bit gaps);
    for (int i = 0; i < BEATS; i++) send_beat(a[i*W +: W], b[i*W +: W], gaps);
    chk("exec_after_load", {30'd0, state_o}, 32'd2);
  endtask

  // Runs a job; without op_last it offers one op beyond the step limit
  task automatic run_job(input logic [N-1:0] a, b, input int nops, input bit use_last,
                         input int code0, input bit gaps);
    int accepted;
    int tries;
    bit ok;
    logic [2:0] c;
    do_start();
    load_operands(a, b, gaps);
    accepted = 0;
    tries = use_last ? nops : MS + 1;
    for (int i = 0; i < tries; i++) begin
      c = (code0 >= 0 && i == 0) ? 3'(code0) : 3'($urandom_range(0, 7));
      send_op(c, use_last && (i == nops - 1), gaps, ok);
      if (ok) begin
        model_acc = ref_fn(int'(c), a, b, model_acc);
        accepted++;
        if ((use_last && i == nops - 1) || accepted == MS) push_result();
      end
    end
    chk("ops_accepted", accepted, use_last ? nops : MS);
    chk("step_err", {31'd0, step_err}, {31'd0, !use_last});
  endtask

  initial begin
    bit ok;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_op_ready", {31'd0, op_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_out_data", {28'd0, out_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_state", {30'd0, state_o}, 0);
    chk("rst_step_err", {31'd0, step_err}, 0);
    cyc(2); rst = 0; cyc(1);

    // op 0 on 0x1234/0x00FF -> 0x0034
    do_start();
    load_operands(16'h1234, 16'h00FF, 0);
    send_op(3'd0, 1, 0, ok);
    chk("op0_accepted", {31'd0, ok}, 1);
    exp_q.push_back({1'b0, 4'h4}); exp_q.push_back({1'b0, 4'h3});
    exp_q.push_back({1'b0, 4'h0}); exp_q.push_back({1'b1, 4'h0});
    model_acc = 16'h0034;

    // op 0 then saturating op 5 on 0xFFFF/0x0002 -> 0x0002
    do_start();
    load_operands(16'hFFFF, 16'h0002, 0);
    send_op(3'd0, 0, 0, ok);
    send_op(3'd5, 1, 0, ok);
    exp_q.push_back({1'b0, 4'h2}); exp_q.push_back({1'b0, 4'h0});
    exp_q.push_back({1'b0, 4'h0}); exp_q.push_back({1'b1, 4'h0});
    model_acc = 16'h0002;

    // step limit without op_last, then the next start clears step_err
    run_job(16'h0F0F, 16'h3C3C, 0, 0, -1, 0);
    run_job(16'hA5A5, 16'h5A5A, 1, 1, 1, 0);

    // three-cycle stall on the second result beat
    begin
      int base;
      run_job($urandom, $urandom, 2, 1, -1, 0);
      base = beats_seen;
      for (int t = 0; t < 50 && beats_seen < base + 1; t++) @(negedge clk);
      stall_cnt = 3;
    end

    // reset in the middle of LOAD after two beats
    do_start();
    send_beat(4'hA, 4'h5, 0);
    send_beat(4'hB, 4'h6, 0);
    @(posedge clk); #1; rst = 1; #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_state", {30'd0, state_o}, 0);
    chk("midrst_out_data", {28'd0, out_data}, 0);
    model_acc = '0;
    cyc(2); rst = 0; cyc(1);
    run_job(16'hC3A1, 16'h7E92, 1, 1, 7, 1);

    // randomized jobs with input gaps and output backpressure
    bp_en = 1;
    for (int j = 0; j < 24; j++) begin
      if ($urandom_range(0, 5) == 0) run_job($urandom, $urandom, 0, 0, -1, 1);
      else run_job($urandom, $urandom, $urandom_range(1, MS), 1, -1, 1);
    end

    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    cyc(3);
    chk("final_idle", {30'd0, state_o}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
